// File: rtl/compare_result_tracker.sv
// Window statistics for the magnitude comparator's C (A>B) / D (A==B) flags: counts gt/eq/lt per window,
// publishes the totals plus the majority class with a done pulse. Optional macro TRACKER_LIVE_EN publishes live counts.
module compare_result_tracker #(
   parameter int CNT_W  = 8,
   parameter int WINDOW = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             in_valid,
   input  logic             C,
   input  logic             D,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] gt_cnt,
   output logic [CNT_W-1:0] eq_cnt,
   output logic [CNT_W-1:0] lt_cnt,
   output logic [1:0]       majority,
   output logic             err
);

   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_t;

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WINDOW - 1);

   state_t           state, state_next;
   logic [CNT_W-1:0] sample_cnt;
   logic [CNT_W-1:0] wk_gt, wk_eq, wk_lt;
   logic [CNT_W-1:0] gt_next, eq_next, lt_next;
   logic             err_next;
   logic             accept, last, clear;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // Strictly largest class wins; any tie for the top (including all zero) reports 00.
   function automatic logic [1:0] majority_of(input logic [CNT_W-1:0] g,
                                              input logic [CNT_W-1:0] e,
                                              input logic [CNT_W-1:0] l);
      if (g > e && g > l)      return 2'b01;
      else if (e > g && e > l) return 2'b10;
      else if (l > g && l > e) return 2'b11;
      else                     return 2'b00;
   endfunction

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      last       = 1'b0;
      clear      = 1'b0;
      gt_next    = wk_gt;
      eq_next    = wk_eq;
      lt_next    = wk_lt;
      err_next   = err;
      case (state)
         S_IDLE: begin
            if (start) begin
               clear      = 1'b1;
               state_next = S_COLLECT;
            end
         end
         S_COLLECT: begin
            if (in_valid) begin
               accept = 1'b1;
               if (sample_cnt == LAST_IDX) begin
                  last       = 1'b1;
                  state_next = S_DONE;
               end
            end
         end
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
      if (clear) begin
         gt_next  = '0;
         eq_next  = '0;
         lt_next  = '0;
         err_next = 1'b0;
      end else if (accept) begin
         // C=1,D=1 is impossible from a healthy comparator: it uses a slot but no class.
         case ({C, D})
            2'b10:   gt_next  = sat_inc(wk_gt);
            2'b01:   eq_next  = sat_inc(wk_eq);
            2'b00:   lt_next  = sat_inc(wk_lt);
            default: err_next = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         sample_cnt <= '0;
         wk_gt      <= '0;
         wk_eq      <= '0;
         wk_lt      <= '0;
         err        <= 1'b0;
         gt_cnt     <= '0;
         eq_cnt     <= '0;
         lt_cnt     <= '0;
         majority   <= 2'b00;
      end else begin
         state <= state_next;
         busy  <= (state_next == S_COLLECT);
         done  <= (state_next == S_DONE);
         if (clear)       sample_cnt <= '0;
         else if (accept) sample_cnt <= sample_cnt + 1'b1;
         wk_gt <= gt_next;
         wk_eq <= eq_next;
         wk_lt <= lt_next;
         err   <= err_next;
`ifdef TRACKER_LIVE_EN
         if (clear) begin
            gt_cnt   <= '0;
            eq_cnt   <= '0;
            lt_cnt   <= '0;
            majority <= 2'b00;
         end else if (accept) begin
            gt_cnt   <= gt_next;
            eq_cnt   <= eq_next;
            lt_cnt   <= lt_next;
            majority <= majority_of(gt_next, eq_next, lt_next);
         end
`else
         if (last) begin
            gt_cnt   <= gt_next;
            eq_cnt   <= eq_next;
            lt_cnt   <= lt_next;
            majority <= majority_of(gt_next, eq_next, lt_next);
         end
`endif
      end
   end

endmodule

// File: doc/compare_result_tracker.md
Name: compare_result_tracker

Overview:
- Downstream consumer of the 8-bit magnitude comparator's result bits: C (A>B) and D (A==B).
- Collects a fixed window of valid comparison results and counts greater / equal / less outcomes.
- Reports the window totals and the majority outcome with a one-cycle done pulse.
- Used by the test/monitor path to summarise operand-stream behaviour without software polling every compare.

Parameters:
- CNT_W, 8: width of sample and class counters; must satisfy 2**CNT_W > WINDOW.
- WINDOW, 16: number of valid samples per collection window; legal range 1 to 2**CNT_W-1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  begin a new window; honoured only in IDLE
- in_valid  input  1  C/D carry a valid comparison result this cycle
- C  input  1  comparator greater flag (A>B)
- D  input  1  comparator equal flag (A==B)
- busy  output  1  high while in COLLECT
- done  output  1  one-cycle pulse when a window completes
- gt_cnt  output  CNT_W  samples with C=1, D=0 in last completed window
- eq_cnt  output  CNT_W  samples with C=0, D=1 in last completed window
- lt_cnt  output  CNT_W  samples with C=0, D=0 in last completed window
- majority  output  2  00 tie/none, 01 gt, 10 eq, 11 lt
- err  output  1  sticky: illegal C=1, D=1 seen in current/last window

Behaviour:
- Interface: one clock, clk; reset rst is synchronous, active-high. All outputs are registered.
- Reset: state=IDLE; busy=0, done=0, gt_cnt=eq_cnt=lt_cnt=0, majority=00, err=0. Internal sample counter and working counters are cleared.
- Reset mid-window: the window is abandoned with no done pulse and all outputs return to reset values in the next cycle.
- IDLE:
  - start=1 clears the working counters and err, then moves to COLLECT on the next edge.
  - Published gt/eq/lt/majority values are held; they are not cleared by start.
  - in_valid in IDLE is ignored.
- COLLECT (busy=1):
  - Each cycle with in_valid=1 increments the sample counter.
  - C=1, D=0: working gt +1.
  - C=0, D=1: working eq +1.
  - C=0, D=0: working lt +1.
  - C=1, D=1 is illegal: it consumes a window slot, increments no class counter, and sets err.
  - start is ignored in COLLECT.
  - Working counters saturate at 2**CNT_W-1 (unreachable with a legal WINDOW; kept as a guard).
- Window completion:
  - On the edge that accepts the WINDOW-th valid sample, move to DONE.
  - In the same edge, copy the working counters to gt_cnt/eq_cnt/lt_cnt and compute majority.
  - Latency: done is high in the cycle immediately after the last sample's accepting edge.
- DONE:
  - Lasts exactly one cycle with done=1 and busy=0, then returns to IDLE.
  - in_valid and start in DONE are ignored. start must be reasserted in IDLE.
- majority: the strictly largest of gt/eq/lt. Any tie for the largest gives 00, including all-zero when every sample was illegal.
- err: remains set until the next accepted start or rst.
- WINDOW=1: a single valid sample completes the window. done follows the start-to-COLLECT transition after one valid cycle.

Optional Feature:
- Macro: TRACKER_LIVE_EN.
- Defined:
  - gt_cnt/eq_cnt/lt_cnt/majority track the working counters every cycle during COLLECT.
  - They are cleared on the start that enters COLLECT.
  - Final values are equal to the non-live build at done.
- Not defined: outputs change only at window completion, as described above.

Test Plan:
- WINDOW=4, rst, then start, then four valid samples (C,D)=(1,0),(1,0),(0,1),(0,0) -> done pulse one cycle after the 4th sample; gt=2, eq=1, lt=1, majority=01, err=0.
- WINDOW=4, valid samples (0,1),(0,0),(0,1),(0,0) -> eq=2, lt=2, majority=00 (tie).
- Gaps: in_valid toggled 1,0,0,1,1,0,1 -> done only after the 4th valid. busy=1 throughout COLLECT; start pulses mid-window change nothing.
- Illegal input: samples (1,1),(1,0),(1,0),(1,0) -> gt=3, eq=0, lt=0, majority=01, err=1. err remains 1 in IDLE and clears on the next start.
- rst asserted after 2 of 4 samples -> no done pulse. Next cycle all outputs are 0 and state is IDLE. A new start plus 4 samples yields correct fresh counts.
- Back-to-back windows: start in the cycle after done -> the second window's counts are independent. Previous results are held through IDLE (non-live build). With TRACKER_LIVE_EN, gt_cnt increments visibly per sample.
